// File: rtl/mips_pkg.sv
// Shared MIPS encoding constants and command classes, used by the program-load
// encoder and by the control decoder.
package mips_pkg;

    localparam logic [5:0] OP_R       = 6'b000000;
    localparam logic [5:0] OP_LW      = 6'b100011;
    localparam logic [5:0] OP_SW      = 6'b101011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [2:0] OP_I_PREFIX = 3'b001;
    localparam logic [5:0] FUNCT_JR   = 6'b001000;

    // Codes 9-15 are reserved and rejected by the encoder.
    typedef enum logic [3:0] {
        CLS_R   = 4'd0,
        CLS_JR  = 4'd1,
        CLS_I   = 4'd2,
        CLS_LW  = 4'd3,
        CLS_SW  = 4'd4,
        CLS_BEQ = 4'd5,
        CLS_BNE = 4'd6,
        CLS_J   = 4'd7,
        CLS_JAL = 4'd8
    } cmd_class_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH,
        ST_DONE
    } enc_state_e;

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: command class plus operand fields to a 32-bit
// MIPS instruction word, with a flag that is low for reserved classes.
module instr_pack
    import mips_pkg::*;
(
    input  logic [3:0]  cmd_class,
    input  logic [2:0]  cmd_iop,
    input  logic [4:0]  cmd_rs,
    input  logic [4:0]  cmd_rt,
    input  logic [4:0]  cmd_rd,
    input  logic [4:0]  cmd_shamt,
    input  logic [5:0]  cmd_funct,
    input  logic [15:0] cmd_imm,
    input  logic [25:0] cmd_target,
    output logic [31:0] word,
    output logic        legal
);

    always_comb begin
        // NOTE: every output gets a default before the case so no latch is inferred.
        word  = '0;
        legal = 1'b1;
        case (cmd_class)
            CLS_R:   word = {OP_R, cmd_rs, cmd_rt, cmd_rd, cmd_shamt, cmd_funct};
            CLS_JR:  word = {OP_R, cmd_rs, 15'b0, FUNCT_JR};
            CLS_I:   word = {OP_I_PREFIX, cmd_iop, cmd_rs, cmd_rt, cmd_imm};
            CLS_LW:  word = {OP_LW, cmd_rs, cmd_rt, cmd_imm};
            CLS_SW:  word = {OP_SW, cmd_rs, cmd_rt, cmd_imm};
            CLS_BEQ: word = {OP_BEQ, cmd_rs, cmd_rt, cmd_imm};
            CLS_BNE: word = {OP_BNE, cmd_rs, cmd_rt, cmd_imm};
            CLS_J:   word = {OP_J, cmd_target};
            CLS_JAL: word = {OP_JAL, cmd_target};
            default: legal = 1'b0;
        endcase
    end

endmodule

// File: rtl/instr_encoder32.sv
// Program loader: accepts encoded-instruction commands and streams the packed
// words into instruction memory, one word per cycle, from a start address.
module instr_encoder32
    import mips_pkg::*;
#(
    parameter int ADDR_W = 14
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_class,
    input  logic [2:0]        cmd_iop,
    input  logic [4:0]        cmd_rs,
    input  logic [4:0]        cmd_rt,
    input  logic [4:0]        cmd_rd,
    input  logic [4:0]        cmd_shamt,
    input  logic [5:0]        cmd_funct,
    input  logic [15:0]       cmd_imm,
    input  logic [25:0]       cmd_target,
    input  logic              cmd_last,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W:0] COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    enc_state_e        state;
    logic [ADDR_W-1:0] wr_ptr;
    logic [31:0]       pack_word;
    logic              pack_legal;
    logic              handshake;

    instr_pack u_pack (
        .cmd_class  (cmd_class),
        .cmd_iop    (cmd_iop),
        .cmd_rs     (cmd_rs),
        .cmd_rt     (cmd_rt),
        .cmd_rd     (cmd_rd),
        .cmd_shamt  (cmd_shamt),
        .cmd_funct  (cmd_funct),
        .cmd_imm    (cmd_imm),
        .cmd_target (cmd_target),
        .word       (pack_word),
        .legal      (pack_legal)
    );

    assign cmd_ready = (state == ST_LOAD);
    assign busy      = (state == ST_LOAD) || (state == ST_FLUSH);
    assign done      = (state == ST_DONE);
    assign handshake = cmd_valid && cmd_ready;

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            wr_ptr     <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            err        <= 1'b0;
            count      <= '0;
        end else begin
            // NOTE: non-blocking assignments keep every register sampling pre-edge values.
            imem_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state  <= ST_LOAD;
                        wr_ptr <= base_addr;
                        count  <= '0;
                        err    <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (handshake) begin
                        if (pack_legal) begin
                            imem_we    <= 1'b1;
                            imem_addr  <= wr_ptr;
                            imem_wdata <= pack_word;
                            wr_ptr     <= wr_ptr + 1'b1;
                            if (count != COUNT_MAX)
                                count <= count + 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                        if (cmd_last)
                            state <= ST_FLUSH;
                    end
                end
                // The final write is on the port during FLUSH; nothing else to wait for.
                ST_FLUSH: state <= ST_DONE;
                ST_DONE:  state <= ST_IDLE;
                default:  state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_encoder32.sv
// Self-checking bench for instr_encoder32: scripted loads plus a vector table,
// with every expected memory write queued on a scoreboard.
module tb_instr_encoder32;

    localparam int ADDR_W = 14;

    typedef struct {
        logic [3:0]  cls;
        logic [2:0]  iop;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  sh;
        logic [5:0]  funct;
        logic [15:0] imm;
        logic [25:0] tgt;
        logic        legal;
        logic [31:0] word;
    } vec_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    logic              clock = 1'b0;
    logic              reset;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [3:0]        cmd_class;
    logic [2:0]        cmd_iop;
    logic [4:0]        cmd_rs, cmd_rt, cmd_rd, cmd_shamt;
    logic [5:0]        cmd_funct;
    logic [15:0]       cmd_imm;
    logic [25:0]       cmd_target;
    logic              cmd_last;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic              busy, done, err;
    logic [ADDR_W:0]   count;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_we_cyc = -10;
    int run_len  = 0;
    int wr_total = 0;
    logic [ADDR_W-1:0] exp_ptr;
    wr_t  exp_q[$];
    vec_t tbl[12];

    always #5 clock = ~clock;

    instr_encoder32 #(.ADDR_W(ADDR_W)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_class  (cmd_class),
        .cmd_iop    (cmd_iop),
        .cmd_rs     (cmd_rs),
        .cmd_rt     (cmd_rt),
        .cmd_rd     (cmd_rd),
        .cmd_shamt  (cmd_shamt),
        .cmd_funct  (cmd_funct),
        .cmd_imm    (cmd_imm),
        .cmd_target (cmd_target),
        .cmd_last   (cmd_last),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .count      (count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [3:0] cls, input logic [2:0] iop,
                                input logic [4:0] rs, input logic [4:0] rt,
                                input logic [4:0] rd, input logic [4:0] sh,
                                input logic [5:0] funct, input logic [15:0] imm,
                                input logic [25:0] tgt, input logic legal,
                                input logic [31:0] word);
        vec_t v;
        v.cls = cls; v.iop = iop; v.rs = rs; v.rt = rt; v.rd = rd; v.sh = sh;
        v.funct = funct; v.imm = imm; v.tgt = tgt; v.legal = legal; v.word = word;
        return v;
    endfunction

    // One clock, then sample on the falling edge and score any write seen.
    task automatic tick();
        wr_t e;
        @(posedge clock);
        @(negedge clock);
        cyc++;
        if (imem_we !== 1'b0) begin
            run_len     = (cyc == last_we_cyc + 1) ? run_len + 1 : 1;
            last_we_cyc = cyc;
            wr_total++;
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got we=%b addr=0x%0h data=0x%0h expected no write",
                         imem_we, imem_addr, imem_wdata);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", 32'(imem_addr), 32'(e.addr));
                check("wr_data", imem_wdata, e.data);
            end
        end
    endtask

    task automatic do_start(input logic [ADDR_W-1:0] base);
        start     = 1'b1;
        base_addr = base;
        tick();
        start   = 1'b0;
        exp_ptr = base;
        check("start_busy", 32'(busy), 32'd1);
        check("start_ready", 32'(cmd_ready), 32'd1);
        check("start_err_clear", 32'(err), 32'd0);
        check("start_count_clear", 32'(count), 32'd0);
    endtask

    task automatic send(input vec_t v, input logic last);
        cmd_valid  = 1'b1;
        cmd_class  = v.cls;
        cmd_iop    = v.iop;
        cmd_rs     = v.rs;
        cmd_rt     = v.rt;
        cmd_rd     = v.rd;
        cmd_shamt  = v.sh;
        cmd_funct  = v.funct;
        cmd_imm    = v.imm;
        cmd_target = v.tgt;
        cmd_last   = last;
        if (v.legal) begin
            exp_q.push_back('{exp_ptr, v.word});
            exp_ptr = exp_ptr + 1'b1;
        end
        tick();
        cmd_valid = 1'b0;
        cmd_last  = 1'b0;
    endtask

    // Called right after the last handshake: FLUSH now, DONE next, then IDLE.
    task automatic finish_load(input string tag, input int exp_count, input logic exp_err);
        check({tag, "_flush_busy"}, 32'(busy), 32'd1);
        check({tag, "_flush_ready"}, 32'(cmd_ready), 32'd0);
        tick();
        check({tag, "_done_pulse"}, 32'(done), 32'd1);
        check({tag, "_done_busy"}, 32'(busy), 32'd0);
        check({tag, "_done_we"}, 32'(imem_we), 32'd0);
        tick();
        check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
        check({tag, "_count"}, 32'(count), 32'(exp_count));
        check({tag, "_err"}, 32'(err), 32'(exp_err));
        check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_we"}, 32'(imem_we), 32'd0);
        check({tag, "_addr"}, 32'(imem_addr), 32'd0);
        check({tag, "_wdata"}, imem_wdata, 32'd0);
        check({tag, "_ready"}, 32'(cmd_ready), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_count"}, 32'(count), 32'd0);
    endtask

    initial begin
        int w0;
        vec_t illegal12;
        reset = 1'b1; start = 1'b0; base_addr = '0; cmd_valid = 1'b0;
        cmd_class = '0; cmd_iop = '0; cmd_rs = '0; cmd_rt = '0; cmd_rd = '0;
        cmd_shamt = '0; cmd_funct = '0; cmd_imm = '0; cmd_target = '0; cmd_last = 1'b0;

        tbl[0]  = mk(4'd0, 3'd0, 5'd1,  5'd2, 5'd3, 5'd0, 6'h20, 16'h0000, 26'h0,       1'b1, 32'h00221820);
        tbl[1]  = mk(4'd1, 3'd5, 5'd31, 5'd7, 5'd7, 5'd5, 6'h3F, 16'hFFFF, 26'h3FFFFFF, 1'b1, 32'h03E00008);
        tbl[2]  = mk(4'd2, 3'd1, 5'd2,  5'd3, 5'd0, 5'd0, 6'h00, 16'h1234, 26'h0,       1'b1, 32'h24431234);
        tbl[3]  = mk(4'd3, 3'd0, 5'd29, 5'd8, 5'd0, 5'd0, 6'h00, 16'h0004, 26'h0,       1'b1, 32'h8FA80004);
        tbl[4]  = mk(4'd4, 3'd0, 5'd29, 5'd9, 5'd0, 5'd0, 6'h00, 16'h0008, 26'h0,       1'b1, 32'hAFA90008);
        tbl[5]  = mk(4'd5, 3'd0, 5'd4,  5'd5, 5'd0, 5'd0, 6'h00, 16'hFFFF, 26'h0,       1'b1, 32'h1085FFFF);
        tbl[6]  = mk(4'd6, 3'd0, 5'd1,  5'd0, 5'd0, 5'd0, 6'h00, 16'h0010, 26'h0,       1'b1, 32'h14200010);
        tbl[7]  = mk(4'd7, 3'd0, 5'd0,  5'd0, 5'd0, 5'd0, 6'h00, 16'h0000, 26'h0000100, 1'b1, 32'h08000100);
        tbl[8]  = mk(4'd8, 3'd0, 5'd0,  5'd0, 5'd0, 5'd0, 6'h00, 16'h0000, 26'h3FFFFFF, 1'b1, 32'h0FFFFFFF);
        tbl[9]  = mk(4'd0, 3'd0, 5'd5,  5'd6, 5'd7, 5'd3, 6'h08, 16'h0000, 26'h0,       1'b1, 32'h00A638C8);
        tbl[10] = mk(4'd15, 3'd7, 5'd9, 5'd9, 5'd9, 5'd9, 6'h3F, 16'hAAAA, 26'h1555555, 1'b0, 32'h0);
        tbl[11] = mk(4'd2, 3'd7, 5'd0,  5'd1, 5'd0, 5'd0, 6'h00, 16'hABCD, 26'h0,       1'b1, 32'h3C01ABCD);
        illegal12 = mk(4'd12, 3'd0, 5'd1, 5'd1, 5'd1, 5'd1, 6'h01, 16'h0001, 26'h1, 1'b0, 32'h0);

        // Reset state
        repeat (3) tick();
        check_reset_values("reset");
        reset = 1'b0;
        tick();
        check_reset_values("idle");

        // Single R-type load
        do_start(14'h010);
        send(tbl[0], 1'b1);
        finish_load("r_single", 1, 1'b0);

        // Back-to-back LW then SW, no bubble between writes
        do_start(14'h010);
        w0 = wr_total;
        send(tbl[3], 1'b0);
        send(tbl[4], 1'b1);
        check("b2b_writes", 32'(wr_total - w0), 32'd2);
        check("b2b_consecutive", 32'(run_len), 32'd2);
        finish_load("b2b", 2, 1'b0);

        // Pointer wrap from all-ones to zero
        do_start(14'h3FFF);
        send(tbl[7], 1'b0);
        send(mk(4'd8, 3'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'h00, 16'h0, 26'h0000100, 1'b1, 32'h0C000100), 1'b1);
        finish_load("wrap", 2, 1'b0);

        // Illegal class between two BEQs: skipped, no hole in the address sequence
        do_start(14'h020);
        send(tbl[5], 1'b0);
        send(illegal12, 1'b0);
        check("illegal_err_set", 32'(err), 32'd1);
        send(tbl[5], 1'b1);
        finish_load("illegal_mid", 2, 1'b1);

        // Illegal command that is also the last one still ends the load
        do_start(14'h030);
        send(illegal12, 1'b1);
        finish_load("illegal_last", 0, 1'b1);

        // Vector table, back-to-back, with a start pulse that LOAD must ignore
        do_start(14'h100);
        start     = 1'b1;
        base_addr = 14'h2AA;
        for (int i = 0; i < 12; i++)
            send(tbl[i], (i == 11));
        start = 1'b0;
        finish_load("table", 11, 1'b1);

        // Reset in the handshake cycle of a JR: write suppressed, load aborted
        do_start(14'h040);
        cmd_valid  = 1'b1;
        cmd_class  = 4'd1;
        cmd_rs     = 5'd31;
        cmd_last   = 1'b0;
        reset      = 1'b1;
        tick();
        cmd_valid = 1'b0;
        check_reset_values("abort");
        reset = 1'b0;
        tick();
        check_reset_values("abort_idle");

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
